// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
//   Conditions raw board switches/buttons before they reach the LED
//   controller. Each channel passes through a 2-flop synchronizer, then a
//   debounce counter that advances only on prescaler ticks. A changed input
//   is accepted once it has held for STABLE_TICKS consecutive ticks. One-clock
//   rise/fall pulses mark each accepted change.
//
//   Everything runs on the undivided system clock. The prescaler produces a
//   clock enable (tick), so no derived clock is needed.
//
// Parameters
//   N             number of switch channels
//   PRESCALE      clk cycles per debounce tick (>=1)
//   STABLE_TICKS  consecutive ticks a changed input must hold (>=1)
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   sw_raw   asynchronous switch/button pins
//   sw_db    debounced level
//   sw_rise  one-clk pulse when sw_db[i] goes 0->1
//   sw_fall  one-clk pulse when sw_db[i] goes 1->0
//   tick     prescaler enable, high for one clk every PRESCALE clks
// ---------------------------------------------------------------------------
module sw_debounce #(
  parameter int N            = 2,
  parameter int PRESCALE     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_db,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         tick
);

  // The prescaler count needs at least one bit, even when PRESCALE==1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(STABLE_TICKS + 1);

  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DCNT_LAST = DW'(STABLE_TICKS - 1);

  logic [PW-1:0] pcnt;
  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [DW-1:0] dcnt [N];

  // Prescaler. tick is registered, so it goes high in the cycle after pcnt
  // reaches its last value. The first tick comes PRESCALE clks after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PCNT_LAST);
      if (pcnt == PCNT_LAST) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  // Two-flop synchronizer. Only s2 is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Per-channel debounce. The counter clears on every clk in which the
  // synchronized input agrees with the accepted level. Any glitch back to
  // the old level therefore discards all progress. The counter advances only
  // on ticks while the input disagrees. dcnt stops at STABLE_TICKS-1, so it
  // can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_db   <= '0;
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < N; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      sw_rise <= '0;
      sw_fall <= '0;
      for (int i = 0; i < N; i++) begin
        if (s2[i] == sw_db[i]) begin
          dcnt[i] <= '0;
        end else if (tick) begin
          if (dcnt[i] == DCNT_LAST) begin
            // The pulses are registered together with the new level, so
            // they appear in the same clk in which sw_db shows the new value.
            sw_db[i]   <= ~sw_db[i];
            sw_rise[i] <= ~sw_db[i];
            sw_fall[i] <= sw_db[i];
            dcnt[i]    <= '0;
          end else begin
            dcnt[i] <= dcnt[i] + DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
//   Two instances run side by side from one clock and one reset:
//   dut_a (PRESCALE=4, STABLE_TICKS=3) and dut_b (PRESCALE=1, STABLE_TICKS=1).
//   A reference model advances on each rising edge. It works from the
//   behavioural rules:
//     - tick is high after edge e when e>=P and e%P==0, where e counts edges
//       since reset released;
//     - the synchronized input is sw_raw delayed by two edges;
//     - a level is accepted after S ticks in a row with the input disagreeing.
//   Every output of both instances is compared against the model on each
//   falling edge. Directed scenarios add latency and pulse-count checks.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

  localparam int P_A = 4;
  localparam int S_A = 3;
  localparam int P_B = 1;
  localparam int S_B = 1;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0] raw_a, raw_b;
  logic [1:0] db_a, rise_a, fall_a;
  logic [1:0] db_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  sw_debounce #(.N(2), .PRESCALE(P_A), .STABLE_TICKS(S_A)) dut_a (
    .clk(clk), .rst(rst), .sw_raw(raw_a),
    .sw_db(db_a), .sw_rise(rise_a), .sw_fall(fall_a), .tick(tick_a)
  );

  sw_debounce #(.N(2), .PRESCALE(P_B), .STABLE_TICKS(S_B)) dut_b (
    .clk(clk), .rst(rst), .sw_raw(raw_b),
    .sw_db(db_b), .sw_rise(rise_b), .sw_fall(fall_b), .tick(tick_b)
  );

  // scoreboard counters and checking task
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int         m_e;
  logic [1:0] m_db   [2];
  logic [1:0] m_rise [2];
  logic [1:0] m_fall [2];
  logic [1:0] m_h1   [2];
  logic [1:0] m_h2   [2];
  logic       m_tick [2];
  int         m_run  [2][2];
  int         mp, ms;
  logic [1:0] mraw;
  bit         m_tick_used;

  function automatic bit tick_after(input int e, input int p);
    return (e >= p) && (e % p == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_e = 0;
      for (int k = 0; k < 2; k++) begin
        m_db[k] = '0; m_rise[k] = '0; m_fall[k] = '0;
        m_h1[k] = '0; m_h2[k] = '0; m_tick[k] = 1'b0;
        for (int c = 0; c < 2; c++) m_run[k][c] = 0;
      end
    end else begin
      m_e = m_e + 1;
      for (int k = 0; k < 2; k++) begin
        mp   = (k == 0) ? P_A : P_B;
        ms   = (k == 0) ? S_A : S_B;
        mraw = (k == 0) ? raw_a : raw_b;
        // The enable seen at this edge is the tick produced by the previous edge.
        m_tick_used = tick_after(m_e - 1, mp);
        m_rise[k] = '0;
        m_fall[k] = '0;
        for (int c = 0; c < 2; c++) begin
          if (m_h2[k][c] == m_db[k][c]) begin
            m_run[k][c] = 0;
          end else if (m_tick_used) begin
            m_run[k][c] = m_run[k][c] + 1;
            if (m_run[k][c] == ms) begin
              m_db[k][c]   = ~m_db[k][c];
              m_rise[k][c] = m_db[k][c];
              m_fall[k][c] = ~m_db[k][c];
              m_run[k][c]  = 0;
            end
          end
        end
        m_h2[k]   = m_h1[k];
        m_h1[k]   = mraw;
        m_tick[k] = tick_after(m_e, mp);
      end
    end
  end

  task automatic check_all();
    check_eq("a_db",   db_a,   m_db[0]);
    check_eq("a_rise", rise_a, m_rise[0]);
    check_eq("a_fall", fall_a, m_fall[0]);
    check_eq("a_tick", tick_a, m_tick[0]);
    check_eq("a_rise_and_fall", rise_a & fall_a, 2'b00);
    check_eq("b_db",   db_b,   m_db[1]);
    check_eq("b_rise", rise_b, m_rise[1]);
    check_eq("b_fall", fall_b, m_fall[1]);
    check_eq("b_tick", tick_b, m_tick[1]);
    check_eq("b_rise_and_fall", rise_b & fall_b, 2'b00);
  endtask

  // driver: one clock, then check away from the active edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int ticks, lat, found, rises, falls, drops, hold, changed;

    rst = 1'b1; raw_a = 2'b00; raw_b = 2'b00;
    repeat (3) cyc();
    check_eq("reset_db_a", db_a, 2'b00);
    check_eq("reset_tick_a", tick_a, 1'b0);
    rst = 1'b0;

    // 1: idle after reset, tick every 4th clk starting at clk 4
    ticks = 0;
    for (int i = 1; i <= 50; i++) begin
      cyc();
      if (tick_a) ticks++;
      if (i == 4) check_eq("t1_first_tick", tick_a, 1'b1);
    end
    check_eq("t1_tick_count", ticks, 12);
    check_eq("t1_db_idle", db_a, 2'b00);

    // 2: channel 0 rises
    raw_a = 2'b01; found = 0; lat = 0; rises = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (rise_a[0]) rises++;
      if (db_a[0] && found == 0) begin found = 1; lat = i; end
    end
    check_eq("t2_db0_seen", found, 1);
    check_eq("t2_latency_11_to_14", (lat >= 11 && lat <= 14), 1'b1);
    check_eq("t2_rise_count", rises, 1);
    check_eq("t2_db1_low", db_a[1], 1'b0);

    // 3: 6-clk glitch must not be accepted
    raw_a = 2'b00;
    falls = 0; drops = 0;
    for (int i = 0; i < 36; i++) begin
      if (i == 6) raw_a = 2'b01;
      cyc();
      if (fall_a[0]) falls++;
      if (!db_a[0]) drops++;
    end
    check_eq("t3_no_fall", falls, 0);
    check_eq("t3_db0_held", drops, 0);

    // 4: both channels toggle on the same clk
    raw_a = 2'b10; changed = 0;
    for (int i = 0; i < 40 && changed == 0; i++) begin
      cyc();
      if (db_a != 2'b01) begin
        changed = 1;
        check_eq("t4_db_both", db_a, 2'b10);
        check_eq("t4_rise", rise_a, 2'b10);
        check_eq("t4_fall", fall_a, 2'b01);
      end
    end
    check_eq("t4_changed", changed, 1);

    // 5: bring both low, then reset in the middle of a window on channel 1
    raw_a = 2'b00;
    repeat (30) cyc();
    check_eq("t5_pre_db", db_a, 2'b00);
    raw_a = 2'b10;
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    check_eq("t5_rst_db", db_a, 2'b00);
    check_eq("t5_rst_pulses", {rise_a, fall_a}, 4'b0000);
    check_eq("t5_rst_tick", tick_a, 1'b0);
    rst = 1'b0;
    found = 0; lat = 0; rises = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (rise_a[1]) rises++;
      if (db_a[1] && found == 0) begin found = 1; lat = i; end
    end
    check_eq("t5_db1_seen", found, 1);
    check_eq("t5_latency_11_to_14", (lat >= 11 && lat <= 14), 1'b1);
    check_eq("t5_rise1_count", rises, 1);

    // 6: PRESCALE=1, STABLE_TICKS=1 instance follows 3 clks after a step
    raw_b = 2'b01; found = 0; lat = 0; rises = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (rise_b[0]) rises++;
      if (db_b[0] && found == 0) begin found = 1; lat = i; end
    end
    check_eq("t6_latency", lat, 3);
    check_eq("t6_rise_count", rises, 1);

    // 7: random stimulus with occasional resets
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        raw_a = 2'($urandom_range(0, 3));
        hold  = $urandom_range(1, 24);
      end
      hold--;
      if ($urandom_range(0, 2) == 0) raw_b = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
